flow_stats: RTL and testbench
=============================

# flow_stats

Per-flow statistics block sitting directly downstream of `flow_table`. It consumes each lookup result (`flow_key_valid`, `flow_hit`, `flow_id`) together with the packet length, and maintains saturating packet and byte counters per flow plus global miss and out-of-range counters. All counters are exposed on the same 32-bit CSR read/write strobe interface that `axi_addr_decode` drives into `csr` and `flow_table`.

## Interface
- `NUM_FLOWS`, 16: number of tracked flows, 1..24; must match the `flow_table` depth.
- `CNT_W`, 32: counter width, fixed at 32 to match `rdata`.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `flow_key_valid` in 1: one-cycle strobe, lookup result valid.
- `flow_hit` in 1: lookup hit; sampled only with `flow_key_valid`.
- `flow_id` in 16: matched flow index; sampled only on a hit.
- `pkt_len` in 16: packet length in bytes; sampled with `flow_key_valid`.
- `we` in 1: CSR write strobe.
- `waddr` in 8: CSR write byte address.
- `wdata` in 32: CSR write data.
- `wdone` out 1: write-complete pulse.
- `re` in 1: CSR read strobe.
- `raddr` in 8: CSR read byte address.
- `rdata` out 32: read data, held until the next read.
- `rdone` out 1: read-complete pulse.

## Operation
- Address map:
  - 0x00 CTRL (RW): bit0 `enable`, bit1 `clear_on_read`; other bits read 0.
  - 0x04 MISS_CNT (RO).
  - 0x08 OOR_CNT (RO).
  - 0x0C CLEAR_ALL (WO; any write zeroes every counter).
  - 0x40+8*i PKT_CNT[i].
  - 0x44+8*i BYTE_CNT[i], i < NUM_FLOWS.
- Event stage: on `flow_key_valid` with `enable`=1, register the event (hit, id, len). The next cycle applies it:
  - hit with id < NUM_FLOWS: PKT_CNT[id] += 1 and BYTE_CNT[id] += pkt_len.
  - hit with id >= NUM_FLOWS: OOR_CNT += 1.
  - miss: MISS_CNT += 1.
- All counters saturate at 0xFFFFFFFF and never wrap. Byte addition uses a 33-bit sum, clamped.
- Writing any counter address clears that counter, regardless of data. CLEAR_ALL clears every counter. CTRL writes apply directly.
- With `clear_on_read`=1, a read of a counter returns its value and zeroes it. CTRL is not affected.
- Unmapped or out-of-range addresses: reads return 0 with `rdone`; writes have no effect but still pulse `wdone`.
- Clear concurrent with an update of the same counter: the counter ends at the increment value (1, or pkt_len). No event is lost.
- A read concurrent with an update returns the pre-update value.
- `re` and `we` in the same cycle are serviced independently. A CTRL write takes effect for events registered from the next cycle.
- `enable`=0 drops events. An event already registered still commits.

## Timing
- Reset values:
  - All counters 0.
  - CTRL = 0x1 (enabled, no clear-on-read).
  - `rdata`=0, `rdone`=0, `wdone`=0.
  - Event stage empty.
- Event latency: `flow_key_valid` at cycle N updates counters at the edge ending N+1. A read issued at N+2 observes the update.
- Back-to-back events are accepted every cycle with no stall. Consecutive events to the same flow must both count, so there is no read-modify-write hazard (registers, not RAM).
- Read: `re` at N gives `rdata` and a one-cycle `rdone` at N+1.
- Write: `we` at N gives the effect and a one-cycle `wdone` at N+1.
- Asserting `rst` mid-operation immediately clears everything, including a pending event and pulses.

## Structure
- Package `flow_stats_pkg`:
  - Address constants (CTRL, MISS, OOR, CLEAR_ALL, CNT_BASE).
  - CTRL bit positions.
  - `sat_add32` function.
  - Event struct type (hit, id, len).
- Sub-module `flow_stats_cell`: one flow's PKT/BYTE counter pair implementing the saturate, clear and update priority. It is instantiated NUM_FLOWS times via generate.
- Top level holds the event stage, global counters, CTRL and address decode.

## Test plan
- Reset, then read 0x00 / 0x40 / 0x44 -> 0x1 / 0 / 0, each with `rdone` one cycle after `re`.
- Three hits id=2, pkt_len=64, 100, 1500, on consecutive cycles -> PKT_CNT[2]=3, BYTE_CNT[2]=1664; a read at N+4 reflects all three.
- Two misses plus one hit id=20 (NUM_FLOWS=16) -> MISS_CNT=2, OOR_CNT=1, all per-flow counters 0.
- BYTE_CNT[0] preloaded by events to 0xFFFFFF00, then hit len=0x200 -> reads 0xFFFFFFFF; a further hit keeps 0xFFFFFFFF.
- CTRL=0x3, PKT_CNT[1]=5, read 0x48 in the same cycle as an id=1 event -> returns 5; the next read returns 1.
- CTRL=0x0, then 4 hits -> all counters unchanged. Write CLEAR_ALL while an event commits to flow 3 -> PKT_CNT[3]=1, all others 0.

Source files
------------

// File: rtl/flow_stats_pkg.sv
// Shared definitions for the per-flow statistics block: CSR map, CTRL bits,
// the pending-event record and the saturating counter arithmetic.
package flow_stats_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_MISS      = 8'h04;
  localparam logic [7:0] ADDR_OOR       = 8'h08;
  localparam logic [7:0] ADDR_CLEAR_ALL = 8'h0C;
  localparam logic [7:0] ADDR_CNT_BASE  = 8'h40;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_COR = 1;

  localparam logic [31:0] CTRL_MASK  = 32'h0000_0003;
  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

  typedef struct packed {
    logic        hit;
    logic [15:0] id;
    logic [15:0] len;
  } evt_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // A clear coinciding with an update leaves only the new increment, so no event is lost.
  function automatic logic [31:0] cnt_next(input logic [31:0] cur, input logic [31:0] inc,
                                           input logic upd, input logic clr);
    logic [31:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = upd ? inc : 32'h0;
    end else if (upd) begin
      nxt = sat_add32(cur, inc);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/flow_stats_cell.sv
// One flow's saturating packet/byte counter pair with clear-vs-update priority.
// Plain registers so back-to-back updates to the same flow never collide.
module flow_stats_cell
  import flow_stats_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_i,
  input  logic [15:0] len_i,
  input  logic        clr_pkt_i,
  input  logic        clr_byte_i,
  output logic [31:0] pkt_o,
  output logic [31:0] byte_o
);

  logic [31:0] pkt_q, pkt_d;
  logic [31:0] byte_q, byte_d;

  always_comb begin
    pkt_d  = cnt_next(pkt_q, 32'd1, upd_i, clr_pkt_i);
    byte_d = cnt_next(byte_q, {16'h0, len_i}, upd_i, clr_byte_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= '0;
      byte_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      byte_q <= byte_d;
    end
  end

  assign pkt_o  = pkt_q;
  assign byte_o = byte_q;

endmodule

// File: rtl/flow_stats.sv
// Per-flow statistics: registers each lookup result for one cycle, then commits it
// to per-flow, miss or out-of-range counters; all counters readable/clearable over CSR.
module flow_stats
  import flow_stats_pkg::*;
#(
  parameter int NUM_FLOWS = 16,
  parameter int CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flow_key_valid,
  input  logic        flow_hit,
  input  logic [15:0] flow_id,
  input  logic [15:0] pkt_len,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  output logic        wdone,
  input  logic        re,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata,
  output logic        rdone
);

  localparam logic [15:0] NF = 16'(NUM_FLOWS);

  logic [31:0]      ctrl_q, ctrl_d;
  logic             evt_vld_q, evt_vld_d;
  evt_t             evt_q, evt_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] oor_q, oor_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdone_q, wdone_q;

  logic [CNT_W-1:0] pkt_cnt  [NUM_FLOWS];
  logic [CNT_W-1:0] byte_cnt [NUM_FLOWS];

  logic [NUM_FLOWS-1:0] flow_upd;
  logic [NUM_FLOWS-1:0] rd_pkt_sel, rd_byte_sel, wr_pkt_sel, wr_byte_sel;
  logic [NUM_FLOWS-1:0] clr_pkt, clr_byte;

  logic [7:0] roff, woff;
  logic       r_cnt, w_cnt;
  logic       cor, clr_all, clr_miss, clr_oor;
  logic       evt_miss, evt_oor;

  // Counter region decode: 8-byte stride per flow, PKT at +0, BYTE at +4.
  assign roff  = raddr - ADDR_CNT_BASE;
  assign woff  = waddr - ADDR_CNT_BASE;
  assign r_cnt = (raddr >= ADDR_CNT_BASE) && (roff[1:0] == 2'b00);
  assign w_cnt = (waddr >= ADDR_CNT_BASE) && (woff[1:0] == 2'b00);

  always_comb begin
    rd_pkt_sel  = '0;
    rd_byte_sel = '0;
    wr_pkt_sel  = '0;
    wr_byte_sel = '0;
    flow_upd    = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      rd_pkt_sel[i]  = r_cnt && (roff[7:3] == i[4:0]) && !roff[2];
      rd_byte_sel[i] = r_cnt && (roff[7:3] == i[4:0]) &&  roff[2];
      wr_pkt_sel[i]  = w_cnt && (woff[7:3] == i[4:0]) && !woff[2];
      wr_byte_sel[i] = w_cnt && (woff[7:3] == i[4:0]) &&  woff[2];
      flow_upd[i]    = evt_vld_q && evt_q.hit && (evt_q.id == i[15:0]);
    end
  end

  assign cor      = re && ctrl_q[CTRL_COR];
  assign clr_all  = we && (waddr == ADDR_CLEAR_ALL);
  assign clr_miss = clr_all || (we && waddr == ADDR_MISS) || (cor && raddr == ADDR_MISS);
  assign clr_oor  = clr_all || (we && waddr == ADDR_OOR)  || (cor && raddr == ADDR_OOR);
  assign evt_miss = evt_vld_q && !evt_q.hit;
  assign evt_oor  = evt_vld_q && evt_q.hit && (evt_q.id >= NF);

  always_comb begin
    clr_pkt  = '0;
    clr_byte = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      clr_pkt[i]  = clr_all || (we && wr_pkt_sel[i])  || (cor && rd_pkt_sel[i]);
      clr_byte[i] = clr_all || (we && wr_byte_sel[i]) || (cor && rd_byte_sel[i]);
    end
  end

  for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_cell
    flow_stats_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .upd_i      (flow_upd[g]),
      .len_i      (evt_q.len),
      .clr_pkt_i  (clr_pkt[g]),
      .clr_byte_i (clr_byte[g]),
      .pkt_o      (pkt_cnt[g]),
      .byte_o     (byte_cnt[g])
    );
  end

  always_comb begin
    evt_vld_d = flow_key_valid && ctrl_q[CTRL_EN];
    evt_d     = '{hit: flow_hit, id: flow_id, len: pkt_len};
    miss_d    = cnt_next(miss_q, 32'd1, evt_miss, clr_miss);
    oor_d     = cnt_next(oor_q, 32'd1, evt_oor, clr_oor);
    ctrl_d    = (we && waddr == ADDR_CTRL) ? (wdata & CTRL_MASK) : ctrl_q;
  end

  // Reads sample pre-update state; rdata holds until the next read.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = '0;
      case (raddr)
        ADDR_CTRL: rdata_d = ctrl_q;
        ADDR_MISS: rdata_d = miss_q;
        ADDR_OOR:  rdata_d = oor_q;
        default:   ;
      endcase
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (rd_pkt_sel[i])  rdata_d = pkt_cnt[i];
        if (rd_byte_sel[i]) rdata_d = byte_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= CTRL_RESET;
      evt_vld_q <= 1'b0;
      evt_q     <= '0;
      miss_q    <= '0;
      oor_q     <= '0;
      rdata_q   <= '0;
      rdone_q   <= 1'b0;
      wdone_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      evt_vld_q <= evt_vld_d;
      evt_q     <= evt_d;
      miss_q    <= miss_d;
      oor_q     <= oor_d;
      rdata_q   <= rdata_d;
      rdone_q   <= re;
      wdone_q   <= we;
    end
  end

  assign rdata = rdata_q;
  assign rdone = rdone_q;
  assign wdone = wdone_q;

endmodule

// File: tb/tb_flow_stats.sv
// Scoreboard bench for flow_stats: reads push expected data, a monitor pops on rdone.
module tb_flow_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flow_key_valid = 1'b0;
  logic        flow_hit = 1'b0;
  logic [15:0] flow_id = '0;
  logic [15:0] pkt_len = '0;
  logic        we = 1'b0;
  logic [7:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        wdone;
  logic        re = 1'b0;
  logic [7:0]  raddr = '0;
  logic [31:0] rdata;
  logic        rdone;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q  [$];
  logic [7:0]  addr_q [$];
  logic        re_s = 1'b0;
  logic        we_s = 1'b0;

  flow_stats #(.NUM_FLOWS(16), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flow_key_valid (flow_key_valid),
    .flow_hit       (flow_hit),
    .flow_id        (flow_id),
    .pkt_len        (pkt_len),
    .we             (we),
    .waddr          (waddr),
    .wdata          (wdata),
    .wdone          (wdone),
    .re             (re),
    .raddr          (raddr),
    .rdata          (rdata),
    .rdone          (rdone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    re_s <= re;
    we_s <= we;
  end

  // Monitor: strobe timing and read-data scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (re_s || rdone) begin
        total++;
        if (rdone !== re_s) begin
          bad++;
          $display("FAIL rdone_timing got=%0b exp=%0b", rdone, re_s);
        end
      end
      if (we_s || wdone) begin
        total++;
        if (wdone !== we_s) begin
          bad++;
          $display("FAIL wdone_timing got=%0b exp=%0b", wdone, we_s);
        end
      end
      if (rdone) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rdone got=%h exp=none", rdata);
        end else begin
          logic [31:0] e;
          logic [7:0]  a;
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          if (rdata !== e) begin
            bad++;
            $display("FAIL rd@0x%02h got=%h exp=%h", a, rdata, e);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    re = 1'b1; raddr = a;
    exp_q.push_back(e);
    addr_q.push_back(a);
    cyc();
    re = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic ev(input logic h, input logic [15:0] id, input logic [15:0] len);
    flow_key_valid = 1'b1; flow_hit = h; flow_id = id; pkt_len = len;
    cyc();
    flow_key_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] e);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, e);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rdone", {31'h0, rdone}, 32'h0);
    chk("reset_wdone", {31'h0, wdone}, 32'h0);
    cyc();

    // Reset CSR state
    rd(8'h00, 32'h1);
    rd(8'h40, 32'h0);
    rd(8'h44, 32'h0);

    // Three back-to-back hits on flow 2, read at N+4
    ev(1'b1, 16'd2, 16'd64);
    ev(1'b1, 16'd2, 16'd100);
    ev(1'b1, 16'd2, 16'd1500);
    cyc();
    rd(8'h50, 32'd3);
    rd(8'h54, 32'd1664);

    // Misses and out-of-range hit
    wr(8'h0C, 32'h0);
    ev(1'b0, 16'd0, 16'd40);
    ev(1'b0, 16'd7, 16'd40);
    ev(1'b1, 16'd20, 16'd40);
    cyc();
    rd(8'h04, 32'd2);
    rd(8'h08, 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd(8'(8'h40 + 8 * i), 32'h0);
      rd(8'(8'h44 + 8 * i), 32'h0);
    end
    rd(8'hC0, 32'h0);
    rd(8'h0C, 32'h0);

    // Byte saturation on flow 0: 65536*0xFFFF + 0xFF00 = 0xFFFFFF00
    wr(8'h0C, 32'h0);
    for (int i = 0; i < 65536; i++) ev(1'b1, 16'd0, 16'hFFFF);
    ev(1'b1, 16'd0, 16'hFF00);
    cyc();
    rd(8'h44, 32'hFFFF_FF00);
    rd(8'h40, 32'h0001_0001);
    ev(1'b1, 16'd0, 16'h0200);
    cyc();
    rd(8'h44, 32'hFFFF_FFFF);
    ev(1'b1, 16'd0, 16'd5);
    cyc();
    rd(8'h44, 32'hFFFF_FFFF);
    rd(8'h40, 32'h0001_0003);

    // Clear-on-read racing a commit to the same counter
    wr(8'h00, 32'h3);
    wr(8'h0C, 32'h0);
    for (int i = 0; i < 5; i++) ev(1'b1, 16'd1, 16'd10);
    cyc();
    ev(1'b1, 16'd1, 16'd10);
    rd(8'h48, 32'd5);
    rd(8'h48, 32'd1);
    rd(8'h48, 32'd0);
    rd(8'h00, 32'h3);
    rd(8'h00, 32'h3);

    // Disabled: events dropped
    wr(8'h00, 32'h0);
    for (int i = 0; i < 4; i++) ev(1'b1, 16'd3, 16'd7);
    ev(1'b0, 16'd0, 16'd7);
    cyc();
    cyc();
    rd(8'h58, 32'h0);
    rd(8'h5C, 32'h0);
    rd(8'h04, 32'h0);
    rd(8'h00, 32'h0);

    // CLEAR_ALL while a flow-3 event commits
    wr(8'h00, 32'h1);
    ev(1'b1, 16'd5, 16'd4);
    ev(1'b0, 16'd0, 16'd4);
    cyc();
    ev(1'b1, 16'd3, 16'd9);
    wr(8'h0C, 32'h0);
    cyc();
    rd(8'h58, 32'd1);
    rd(8'h5C, 32'd9);
    rd(8'h68, 32'h0);
    rd(8'h6C, 32'h0);
    rd(8'h04, 32'h0);

    // Per-counter write clear and unmapped writes
    wr(8'h5C, 32'hDEAD_BEEF);
    rd(8'h5C, 32'h0);
    rd(8'h58, 32'd1);
    wr(8'h30, 32'h3);
    wr(8'hF8, 32'h3);
    rd(8'h00, 32'h1);
    rd(8'h30, 32'h0);
    rd(8'h58, 32'd1);

    repeat (3) cyc();
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
